memory_slave: RTL and testbench
===============================

// Module: memory_slave
// PURPOSE
//  Single-port register-file memory slave sitting directly downstream of the
//  memory_if bus: consumes wr/rd/addr/wdata driven by the testbench driver and
//  produces rdata plus a one-cycle slv_rsp completion pulse. Adds configurable
//  read latency, busy back-pressure and an error flag for illegal requests.
// PARAMETERS
//  ADDR_WIDTH  4   address bus width
//  DATA_WIDTH  32  data word width
//  MEM_SIZE    16  number of words; legal addresses 0..MEM_SIZE-1 (<= 2**ADDR_WIDTH)
//  RD_LATENCY  2   cycles from read-sampling edge to slv_rsp/rdata valid; legal 1..8
// PORTS
//  clk      input   1           clock, all logic on posedge
//  reset    input   1           asynchronous, active-low reset
//  wr       input   1           write request (1 = write)
//  rd       input   1           read request (1 = read)
//  addr     input   ADDR_WIDTH  word address
//  wdata    input   DATA_WIDTH  write data
//  rdata    output  DATA_WIDTH  read data, registered, held until next read response
//  slv_rsp  output  1           one-cycle completion pulse for every accepted request
//  err      output  1           qualifies slv_rsp: 1 = request rejected
//  busy     output  1           1 = request in flight, new requests ignored
// BEHAVIOUR
//  Reset (reset=0, async): state->IDLE, count->0, rdata=0, slv_rsp=0, err=0,
//   busy=0, all MEM_SIZE words cleared to 0; in-flight request dropped, no slv_rsp.
//  FSM states: IDLE, RD_WAIT, RESP. busy = (state != IDLE).
//  IDLE: sample wr/rd/addr/wdata each posedge; wr=rd=0 -> stay IDLE.
//   wr=1,rd=0, addr<MEM_SIZE: mem[addr]<=wdata at sampling edge; ->RESP, err<=0.
//   rd=1,wr=0, addr<MEM_SIZE: latch addr; RD_LATENCY=1 -> RESP with
//    rdata<=mem[addr]; else ->RD_WAIT, count<=RD_LATENCY-1.
//   wr=1,rd=1 (either address): no memory change, rdata unchanged; ->RESP, err<=1.
//   addr>=MEM_SIZE with wr xor rd: no write, rdata unchanged; ->RESP, err<=1.
//  RD_WAIT: count decrements each cycle; when count==1 -> RESP with
//   rdata<=mem[latched addr], err<=0. Inputs ignored.
//  RESP: slv_rsp=1 for exactly this cycle; inputs ignored; next -> IDLE.
//   slv_rsp and err are registered outputs; err=0 whenever slv_rsp=0.
//  Latency: write/error response 1 cycle after sampling edge; read response
//   RD_LATENCY cycles after it. Max throughput: one request per 2 cycles (writes).
//  Requests asserted while busy=1 are dropped silently; upstream holds or re-issues.
//  No read/write hazard: memory cannot change while a read is in flight.
//  count width $clog2(RD_LATENCY+1); no wrap beyond RD_LATENCY.
// TESTING
//  1. reset=0 then release; rd addr=3 -> after RD_LATENCY=2 cycles slv_rsp=1,
//     rdata=0, err=0.
//  2. wr addr=5 wdata=32'hDEAD_BEEF -> slv_rsp next cycle err=0; rd addr=5 ->
//     2 cycles later rdata=32'hDEAD_BEEF, slv_rsp=1 for exactly one cycle.
//  3. wr=rd=1 addr=2 wdata=32'h1 -> slv_rsp=1 err=1 next cycle; rd addr=2
//     returns previous contents (0), rdata unchanged during error response.
//  4. Parameterise MEM_SIZE=12; wr addr=14 -> err=1, no write; rd addr=14 -> err=1,
//     rdata holds last value.
//  5. rd addr=1 then wr addr=1 wdata=7 on next cycle (busy=1) -> write dropped;
//     rd addr=1 returns old value; busy high RD_LATENCY cycles per read.
//  6. reset=0 during RD_WAIT -> no slv_rsp, busy=0 and rdata=0 immediately;
//     after release all words read 0; sweep RD_LATENCY=1 and 8.

Source files
------------

// File: rtl/memory_slave.sv
// memory_slave: register-file memory slave with read latency, busy back-pressure and error flag
//   clk      posedge clock
//   reset    asynchronous active-low reset; clears state, outputs and all words
//   wr, rd   request strobes, sampled only while idle
//   addr     word address, legal below MEM_SIZE
//   wdata    write data
//   rdata    registered read data, held until the next read response
//   slv_rsp  one-cycle completion pulse per accepted request
//   err      qualifies slv_rsp: request rejected
//   busy     request in flight, new requests dropped
module memory_slave #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16,
  parameter int RD_LATENCY = 2
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  slv_rsp,
  output logic                  err,
  output logic                  busy
);
  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [CW-1:0] CNT_INIT = CW'(RD_LATENCY - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, rd_addr;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic legal, rd_ok, do_wr, do_rd, err_nxt;
  assign legal = {1'b0, addr} < LIM;
  assign rd_ok = rd && !wr && legal;
  assign busy = state != IDLE;
  // a single-cycle read completes straight from IDLE using the live address
  assign rd_addr = state == IDLE ? addr : addr_q;
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    err_nxt = 1'b0;
    do_wr = 1'b0;
    do_rd = 1'b0;
    case (state)
      IDLE: begin
        if (wr || rd) begin
          state_nxt = rd_ok && RD_LATENCY > 1 ? RD_WAIT : RESP;
          count_nxt = rd_ok && RD_LATENCY > 1 ? CNT_INIT : count;
          err_nxt = (wr && rd) || !legal;
          do_wr = wr && !rd && legal;
          do_rd = rd_ok && RD_LATENCY == 1;
        end
      end
      RD_WAIT: begin
        count_nxt = count - ONE;
        state_nxt = count == ONE ? RESP : RD_WAIT;
        do_rd = count == ONE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      addr_q <= '0;
      rdata <= '0;
      slv_rsp <= 1'b0;
      err <= 1'b0;
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      slv_rsp <= state_nxt == RESP;
      err <= err_nxt;
      if (state == IDLE) addr_q <= addr;
      if (do_wr) mem[addr] <= wdata;
      if (do_rd) rdata <= mem[rd_addr];
    end
  end
endmodule

// File: tb/tb_memory_slave.sv
// tb_memory_slave: scoreboard bench driving three memory_slave variants with one stimulus stream
module tb_memory_slave;
  logic clk = 1'b0, reset = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [3:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata [3];
  logic [2:0] slv_rsp, err, busy;
  logic [32:0] q0[$], q1[$], q2[$];
  logic [31:0] mm [3][16];
  logic [31:0] last [3];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  memory_slave #(.RD_LATENCY(2)) d0 (.clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata[0]), .slv_rsp(slv_rsp[0]), .err(err[0]), .busy(busy[0]));
  memory_slave #(.MEM_SIZE(12), .RD_LATENCY(1)) d1 (.clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr),
    .wdata(wdata), .rdata(rdata[1]), .slv_rsp(slv_rsp[1]), .err(err[1]), .busy(busy[1]));
  memory_slave #(.RD_LATENCY(8)) d2 (.clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata[2]), .slv_rsp(slv_rsp[2]), .err(err[2]), .busy(busy[2]));

  function automatic int lat(int i);
    return i == 0 ? 2 : i == 1 ? 1 : 8;
  endfunction

  function automatic int msz(int i);
    return i == 1 ? 12 : 16;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [32:0] e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(input int i, output logic [32:0] e, output bit ok);
    ok = 1'b0;
    e = '0;
    case (i)
      0: if (q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() != 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // reference behaviour of one request for each variant
  task automatic model(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d);
    for (int i = 0; i < 3; i++) begin
      if (w || r) begin
        if ((w && r) || int'(a) >= msz(i)) push(i, {1'b1, last[i]});
        else if (w) begin
          mm[i][a] = d;
          push(i, {1'b0, last[i]});
        end else begin
          last[i] = mm[i][a];
          push(i, {1'b0, last[i]});
        end
      end
    end
  endtask

  task automatic wait_idle(output int bc [3]);
    int n;
    bc = '{0, 0, 0};
    n = 0;
    while (busy != 3'b000 && n < 20) begin
      for (int i = 0; i < 3; i++) if (busy[i]) bc[i]++;
      @(negedge clk);
      n++;
    end
    if (busy != 3'b000) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%b required 000", busy);
    end
  endtask

  task automatic req(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d);
    int bc [3];
    wr = w;
    rd = r;
    addr = a;
    wdata = d;
    model(w, r, a, d);
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    wait_idle(bc);
    for (int i = 0; i < 3; i++)
      check($sformatf("busy_cycles d%0d a=%0d", i, a), 64'(bc[i]),
            64'((r && !w && int'(a) < msz(i)) ? lat(i) : 1));
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      if (slv_rsp[i]) begin
        pop(i, e, ok);
        if (!ok) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp d%0d: slv_rsp=1 required no response", i);
        end else begin
          check($sformatf("rsp_err d%0d", i), 64'(err[i]), 64'(e[32]));
          check($sformatf("rsp_rdata d%0d", i), 64'(rdata[i]), 64'(e[31:0]));
        end
      end else check($sformatf("err_idle d%0d", i), 64'(err[i]), 64'(0));
    end
  end

  initial begin
    int bc [3];
    for (int i = 0; i < 3; i++) begin
      last[i] = '0;
      for (int j = 0; j < 16; j++) mm[i][j] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_rdata d%0d", i), 64'(rdata[i]), 64'(0));
    end
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_rsp", 64'(slv_rsp), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    req(1'b0, 1'b1, 4'd3, '0);
    req(1'b1, 1'b0, 4'd5, 32'hDEAD_BEEF);
    req(1'b0, 1'b1, 4'd5, '0);
    req(1'b1, 1'b1, 4'd2, 32'h1);
    req(1'b0, 1'b1, 4'd2, '0);
    req(1'b1, 1'b0, 4'd14, 32'hCAFE_F00D);
    req(1'b0, 1'b1, 4'd14, '0);
    req(1'b1, 1'b0, 4'd11, 32'h0000_B00B);
    req(1'b0, 1'b1, 4'd11, '0);
    req(1'b1, 1'b0, 4'd12, 32'h0000_0012);
    req(1'b0, 1'b1, 4'd12, '0);
    req(1'b1, 1'b0, 4'd1, 32'h0000_1111);
    // write issued one cycle into a read must be dropped by every variant
    rd = 1'b1;
    addr = 4'd1;
    model(1'b0, 1'b1, 4'd1, '0);
    @(negedge clk);
    check("busy_during_drop", 64'(busy), 64'(3'b111));
    rd = 1'b0;
    wr = 1'b1;
    wdata = 32'd7;
    @(negedge clk);
    wr = 1'b0;
    wait_idle(bc);
    req(1'b0, 1'b1, 4'd1, '0);
    // reset mid-read: only the single-cycle variant has already answered
    rd = 1'b1;
    addr = 4'd5;
    last[1] = mm[1][5];
    push(1, {1'b0, last[1]});
    @(negedge clk);
    rd = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'(0));
    check("midreset_rsp", 64'(slv_rsp), 64'(0));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midreset_rdata d%0d", i), 64'(rdata[i]), 64'(0));
      last[i] = '0;
      for (int j = 0; j < 16; j++) mm[i][j] = '0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    for (int a = 0; a < 16; a++) req(1'b0, 1'b1, 4'(a), '0);
    repeat (3) @(negedge clk);
    check("queue_left d0", 64'(q0.size()), 64'(0));
    check("queue_left d1", 64'(q1.size()), 64'(0));
    check("queue_left d2", 64'(q2.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
